vector_seq_ctrl: RTL and testbench
==================================

Name: vector_seq_ctrl

Overview:
Element-serial sequencer that executes one vector instruction over the scalar register-file ports. It holds the main pipeline, then walks elements 0..vlen-1. For each element it drives ra1/ra2 (base+i), captures the external ALU result, and issues a registered write (wa3/wd3/we3) one cycle later. It detects read-after-pending-write hazards and inserts bubbles. It sits between the decoder and regfile/ALU and takes over the regfile ports while busy.

Parameters:
MAX_LEN, 5, maximum legal vector length (elements).
AW, 4, register address width.
DW, 32, data width.

Ports:
clk  in  1  clock, rising-edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request to execute a vector op; sampled only in IDLE.
vlen  in  4  element count.
base_a  in  AW  first source register.
base_b  in  AW  second source register.
base_d  in  AW  destination register.
alu_y  in  DW  combinational ALU result for the element currently issued.
ra1  out  AW  regfile read address A.
ra2  out  AW  regfile read address B.
wa3  out  AW  regfile write address (registered).
wd3  out  DW  regfile write data (registered).
we3  out  1  regfile write enable (registered).
issue  out  1  high in a cycle where an element is issued; ALU must be valid.
elem_idx  out  3  index of the element currently being read.
busy  out  1  state != IDLE; stalls fetch/decode.
done  out  1  one-cycle completion pulse.
err  out  1  one-cycle illegal-request pulse.

Behaviour:
- Reset (synchronous, any state): state=IDLE. ra1=ra2=wa3=0, wd3=0, we3=0, issue=0, elem_idx=0, busy=0, done=0, err=0. Writes already performed are not undone. we3 is 0 in the cycle after reset is sampled.
- Legality check on an accepted start uses a 5-bit sum: illegal if vlen==0, vlen>MAX_LEN, or base_x+vlen-1 > 14 for any of a/b/d (r15 is never addressed; no wrap).
- States: IDLE, RUN, DRAIN, DONE, ERR.
- IDLE: when start=1, latch vlen and the three bases, set i=0. Go to ERR if the request is illegal, else RUN. start=1 in any other state is ignored.
- ERR: err=1 and busy=1 for one cycle, no writes, then IDLE.
- RUN, per cycle:
  - ra1=base_a+i, ra2=base_b+i, elem_idx=i.
  - Hazard if pending write valid (we3=1 this cycle) and wa3 equals ra1 or ra2.
  - No hazard: issue=1. At the edge, wa3<=base_d+i, wd3<=alu_y, we3<=1, i<=i+1. Go to DRAIN after issuing i=vlen-1.
  - Hazard: issue=0, i holds, we3<=0 at the edge. The pending write completes this cycle and the element is reissued next cycle.
- DRAIN: final write in flight (we3=1). No issue. Next state is DONE and we3<=0.
- DONE: done=1 for one cycle, busy=1, then IDLE. A start in DONE is ignored and must be re-presented in IDLE.
- Latency with no hazards: start sampled at edge 0 → first issue in cycle 1, last write in cycle vlen+1, done in cycle vlen+2. Each hazard adds exactly one cycle.
- Read semantics: element i observes the results of all elements < i, i.e. element-sequential semantics.
- we3 is asserted only in RUN/DRAIN and is never high for two cycles to the same wa3.
- ra1/ra2 hold their last values outside RUN; the regfile ignores them because we3=0 and the decoder is stalled.

Test Plan:
- vlen=3, a=0, b=4, d=8, alu_y=ra1+ra2 model, r0..r6 preloaded 1..7 → writes r8=6, r9=8, r10=10 in cycles 2,3,4; done in cycle 5; busy 1 during cycles 1–5.
- Hazard: vlen=3, a=2, d=3, b=10 → bubbles in cycles 2 and 4; writes r3, r4, r5 in cycles 2, 4, 6; done in cycle 7. Each write uses the freshly written predecessor (chain propagation).
- Illegal requests: vlen=0; vlen=6; a=12 with vlen=4 (reaches r15) → err pulse one cycle, no we3, back to IDLE, busy for exactly one cycle.
- start held high continuously through two ops → second op accepted only in the IDLE cycle after done; no overlap of we3.
- Reset asserted mid-RUN after the first write of a vlen=5 op → next cycle all outputs at reset values; only element 0 written; a new start then works normally.
- vlen=MAX_LEN=5, d=10 → r10..r14 written, done in cycle 7; r15 never addressed.

Source files
------------

// File: rtl/vector_seq_ctrl.sv
// Element-serial vector sequencer: borrows the scalar regfile ports to run one
// vector op element by element, with a registered write-back and one-bubble hazard stall.
module vector_seq_ctrl #(
  parameter int MAX_LEN = 5,
  parameter int AW      = 4,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    vlen,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  input  logic [AW-1:0] base_d,
  input  logic [DW-1:0] alu_y,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic          we3,
  output logic          issue,
  output logic [2:0]    elem_idx,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  localparam int SW = AW + 1;
  // Highest register a vector may touch; the top register is reserved.
  localparam logic [SW-1:0] TOP_REG   = SW'((1 << AW) - 2);
  localparam logic [3:0]    MAX_LEN_V = 4'(MAX_LEN);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    vlen_q;
  logic [AW-1:0] base_a_q;
  logic [AW-1:0] base_b_q;
  logic [AW-1:0] base_d_q;
  logic [2:0]    idx;
  logic [2:0]    idx_nxt;
  logic [AW-1:0] ra1_nxt;
  logic [AW-1:0] ra2_nxt;
  logic          illegal;
  logic          hazard;
  logic          last_elem;

  function automatic logic over_top(input logic [AW-1:0] b, input logic [3:0] n);
    logic [SW-1:0] s;
    s = {1'b0, b} + SW'(n) - SW'(1);
    return s > TOP_REG;
  endfunction

  assign illegal = (vlen == 4'd0) || (vlen > MAX_LEN_V) ||
                   over_top(base_a, vlen) || over_top(base_b, vlen) ||
                   over_top(base_d, vlen);

  // Only the immediately preceding element can still be in flight.
  assign hazard    = we3 && ((wa3 == ra1) || (wa3 == ra2));
  assign issue     = (state == S_RUN) && !hazard;
  assign last_elem = ({1'b0, idx} == (vlen_q - 4'd1));

  assign elem_idx = idx;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ra1_nxt   = ra1;
    ra2_nxt   = ra2;
    case (state)
      S_IDLE: begin
        if (start) begin
          idx_nxt = 3'd0;
          if (illegal) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_RUN;
            ra1_nxt   = base_a;
            ra2_nxt   = base_b;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          if (last_elem) begin
            state_nxt = S_DRAIN;
          end else begin
            idx_nxt = idx + 3'd1;
            ra1_nxt = base_a_q + AW'(idx + 3'd1);
            ra2_nxt = base_b_q + AW'(idx + 3'd1);
          end
        end
      end
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= 3'd0;
      vlen_q   <= 4'd0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_d_q <= '0;
      ra1      <= '0;
      ra2      <= '0;
      wa3      <= '0;
      wd3      <= '0;
      we3      <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      ra1   <= ra1_nxt;
      ra2   <= ra2_nxt;
      we3   <= issue;
      if (issue) begin
        wa3 <= base_d_q + AW'(idx);
        wd3 <= alu_y;
      end
      if ((state == S_IDLE) && start) begin
        vlen_q   <= vlen;
        base_a_q <= base_a;
        base_b_q <= base_b;
        base_d_q <= base_d;
      end
    end
  end

  // A write can only come from an issue in RUN, landing in RUN or DRAIN.
  a_we3_state : assert property (@(posedge clk) disable iff (reset)
    we3 |-> ((state == S_RUN) || (state == S_DRAIN)));

endmodule

// File: tb/tb_vector_seq_ctrl.sv
// Bench for vector_seq_ctrl: behavioural regfile + adder ALU, scoreboard of expected
// writes/done/err with their cycle numbers, checked as the DUT produces them.
module tb_vector_seq_ctrl;
  localparam int MAX_LEN = 5;
  localparam int AW      = 4;
  localparam int DW      = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    vlen;
  logic [AW-1:0] base_a, base_b, base_d;
  logic [DW-1:0] alu_y;
  logic [AW-1:0] ra1, ra2, wa3;
  logic [DW-1:0] wd3;
  logic          we3, issue, busy, done, err;
  logic [2:0]    elem_idx;
  logic          init;

  vector_seq_ctrl #(.MAX_LEN(MAX_LEN), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .vlen(vlen),
    .base_a(base_a), .base_b(base_b), .base_d(base_d), .alu_y(alu_y),
    .ra1(ra1), .ra2(ra2), .wa3(wa3), .wd3(wd3), .we3(we3),
    .issue(issue), .elem_idx(elem_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] rf [16];
  always @(posedge clk) begin
    if (init) begin
      for (int k = 0; k < 16; k++) rf[k] <= DW'(k + 1);
    end else if (we3) begin
      rf[wa3] <= wd3;
    end
  end
  assign alu_y = rf[ra1] + rf[ra2];

  typedef struct {
    int            cyc;
    logic [3:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           wq[$];
  int            dq[$];
  int            eq[$];
  logic [DW-1:0] mrf [16];
  int            n_total = 0;
  int            n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (we3) begin
      if (wq.size() == 0) begin
        chk("we3_expected", {31'b0, we3}, 32'd0);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr", {28'b0, wa3}, {28'b0, e.addr});
        chk("wr_data", wd3, e.data);
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("done_expected", {31'b0, done}, 32'd0);
      else chk("done_cycle", cyc, dq.pop_front());
    end
    if (err) begin
      if (eq.size() == 0) chk("err_expected", {31'b0, err}, 32'd0);
      else chk("err_cycle", cyc, eq.pop_front());
    end
  end

  // Expected results from element-sequential semantics; a bubble is needed exactly
  // when an element reads the destination of its immediate predecessor.
  task automatic push_op(input int v, input int a, input int b, input int d,
                         input int base, input int nwr, input bit with_end,
                         output int end_rel);
    bit bad;
    int t;
    bad = (v == 0) || (v > MAX_LEN) || (a + v - 1 > 14) || (b + v - 1 > 14) ||
          (d + v - 1 > 14);
    if (bad) begin
      end_rel = 1;
      if (with_end) eq.push_back(base + 1);
    end else begin
      t = 0;
      for (int i = 0; i < v; i++) begin
        bit h;
        h = (i > 0) && ((a + i == d + i - 1) || (b + i == d + i - 1));
        t = (i == 0) ? 1 : t + 1 + int'(h);
        if (i < nwr) begin
          logic [DW-1:0] dat;
          dat = mrf[a + i] + mrf[b + i];
          mrf[d + i] = dat;
          wq.push_back('{base + t + 1, 4'(d + i), dat});
        end
      end
      end_rel = t + 2;
      if (with_end) dq.push_back(base + end_rel);
    end
  endtask

  task automatic drive_req(input int v, input int a, input int b, input int d);
    vlen   = 4'(v);
    base_a = AW'(a);
    base_b = AW'(b);
    base_d = AW'(d);
  endtask

  task automatic wait_end(output int busy_cnt);
    bit fin;
    fin = 0;
    busy_cnt = 0;
    for (int k = 0; k < 60 && !fin; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done || err) fin = 1;
    end
    if (!fin) chk("timeout_end", {31'b0, done | err}, 32'd1);
  endtask

  task automatic run_op(input int v, input int a, input int b, input int d);
    int base, rel, bc;
    @(negedge clk);
    drive_req(v, a, b, d);
    start = 1'b1;
    base = cyc;
    push_op(v, a, b, d, base, 99, 1, rel);
    @(posedge clk);
    #1 start = 1'b0;
    wait_end(bc);
    chk("busy_len", bc, rel);
    @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_we3", {31'b0, we3}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_ra1"}, {28'b0, ra1}, 32'd0);
    chk({pfx, "_ra2"}, {28'b0, ra2}, 32'd0);
    chk({pfx, "_wa3"}, {28'b0, wa3}, 32'd0);
    chk({pfx, "_wd3"}, wd3, 32'd0);
    chk({pfx, "_we3"}, {31'b0, we3}, 32'd0);
    chk({pfx, "_issue"}, {31'b0, issue}, 32'd0);
    chk({pfx, "_idx"}, {29'b0, elem_idx}, 32'd0);
    chk({pfx, "_busy"}, {31'b0, busy}, 32'd0);
    chk({pfx, "_done"}, {31'b0, done}, 32'd0);
    chk({pfx, "_err"}, {31'b0, err}, 32'd0);
  endtask

  initial begin
    int base, r1, r2, bc;
    reset = 1'b1;
    init  = 1'b1;
    start = 1'b0;
    drive_req(0, 0, 0, 0);
    for (int k = 0; k < 16; k++) mrf[k] = DW'(k + 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    init = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");

    run_op(3, 0, 4, 8);      // r8=6, r9=8, r10=10
    run_op(3, 2, 10, 3);     // chained: bubble before every element after the first
    run_op(0, 0, 0, 0);
    run_op(6, 0, 0, 0);
    run_op(4, 12, 0, 0);     // would reach r15

    // start held high across two ops: second is taken in the IDLE cycle after done
    @(negedge clk);
    drive_req(2, 0, 1, 11);
    start = 1'b1;
    base = cyc;
    push_op(2, 0, 1, 11, base, 99, 1, r1);
    push_op(3, 8, 9, 12, base + r1 + 1, 99, 1, r2);
    @(posedge clk);
    #1 drive_req(3, 8, 9, 12);
    wait_end(bc);
    chk("hold_busy1", bc, r1);
    @(posedge clk);
    @(negedge clk);
    chk("hold_gap_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    wait_end(bc);
    chk("hold_busy2", bc, r2);
    @(negedge clk);

    // reset in the middle of a run, right as the first write lands
    @(negedge clk);
    drive_req(5, 0, 5, 10);
    start = 1'b1;
    base = cyc;
    push_op(5, 0, 5, 10, base, 1, 0, r1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    chk("midrst_wq_empty", wq.size(), 32'd0);
    run_op(5, 0, 5, 10);

    run_op(5, 0, 1, 10);     // full length, r10..r14

    for (int n = 0; n < 6; n++) begin
      int v, a, b, d;
      v = $urandom_range(1, MAX_LEN);
      a = $urandom_range(0, 15 - v);
      b = $urandom_range(0, 15 - v);
      d = $urandom_range(0, 15 - v);
      if ((n % 2 == 0) && (a + 1 <= 15 - v)) d = a + 1;
      run_op(v, a, b, d);
    end

    repeat (3) @(negedge clk);
    chk("final_wq", wq.size(), 32'd0);
    chk("final_dq", dq.size(), 32'd0);
    chk("final_eq", eq.size(), 32'd0);
    for (int k = 0; k < 16; k++) chk("final_rf", rf[k], mrf[k]);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
